// File: rtl/udma_smi_seq.sv
// Command sequencer for the uDMA SMI (MDIO) controller: command FIFO, one controller
// transaction per command, read responses on the RX stream. Watchdog: SMI_SEQ_TIMEOUT_EN.
module udma_smi_seq #(
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        clr_i,
  input  logic [31:0] cmd_data_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        smi_start_o,
  output logic        smi_rw_o,
  output logic [4:0]  smi_phy_addr_o,
  output logic [4:0]  smi_reg_addr_o,
  output logic [15:0] smi_wr_data_o,
  input  logic        smi_busy_i,
  input  logic        smi_nd_i,
  input  logic [15:0] smi_rd_data_i,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam int unsigned AW = $clog2(CMD_DEPTH);
  // Stored entry is {op, phy, reg, data}; the ignored bits [29:26] are never kept.
  localparam int unsigned CW = 28;

  typedef enum logic [2:0] {StIdle, StIssue, StAccept, StDone, StPush} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   fifo_q [CMD_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     fill_q, fill_d;
  logic [CW-1:0]   head;
  logic            push, pop;
  logic            rw_q, rw_d;
  logic [4:0]      phy_q, phy_d, reg_q, reg_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [31:0]     rsp_q, rsp_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            timeout_q, timeout_d;
  logic            wd_hit;
  logic            unused_cmd;

  assign unused_cmd  = ^cmd_data_i[29:26];
  // Depth is a power of two, so the fill MSB is set exactly when full.
  assign cmd_ready_o = ~fill_q[AW];
  assign push        = cmd_valid_i & cmd_ready_o;
  assign head        = fifo_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= {cmd_data_i[31:30], cmd_data_i[25:0]};
  end

`ifdef SMI_SEQ_TIMEOUT_EN
  logic [31:0] wd_cnt_q;
  logic        wd_run;

  assign wd_run = (state_q == StAccept) || (state_q == StDone);
  assign wd_hit = wd_run && (wd_cnt_q == TIMEOUT_CYCLES - 1);

  // Restarts on every state change so ACCEPT and DONE each get the full budget.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wd_cnt_q <= '0;
    end else if (wd_run && (state_d == state_q)) begin
      wd_cnt_q <= wd_cnt_q + 32'd1;
    end else begin
      wd_cnt_q <= '0;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign wd_hit         = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    rw_d        = rw_q;
    phy_d       = phy_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    timeout_d   = timeout_q;

    unique case (state_q)
      StIdle: begin
        if (fill_q != '0) begin
          if (head[27]) begin
            pop = 1'b1;
          end else if (!smi_busy_i) begin
            pop     = 1'b1;
            rw_d    = ~head[26];
            phy_d   = head[25:21];
            reg_d   = head[20:16];
            wdata_d = head[15:0];
            state_d = StIssue;
          end
        end
      end
      StIssue: state_d = StAccept;
      StAccept, StDone: begin
        if (wd_hit) begin
          timeout_d = 1'b1;
          if (rw_q) begin
            state_d = StIdle;
          end else begin
            rsp_d       = {1'b1, phy_q, reg_q, 5'd0, 16'h0000};
            rsp_valid_d = 1'b1;
            state_d     = StPush;
          end
        end else if (state_q == StAccept) begin
          if (smi_busy_i) state_d = StDone;
        end else if (rw_q) begin
          if (!smi_busy_i) state_d = StIdle;
        end else if (smi_nd_i) begin
          rsp_d       = {1'b0, phy_q, reg_q, 5'd0, smi_rd_data_i};
          rsp_valid_d = 1'b1;
          state_d     = StPush;
        end
      end
      StPush: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (clr_i) begin
      state_d     = StIdle;
      pop         = 1'b0;
      rsp_d       = '0;
      rsp_valid_d = 1'b0;
      timeout_d   = 1'b0;
    end
  end

  always_comb begin
    fill_d = fill_q;
    if (clr_i) begin
      fill_d = '0;
    end else if (push && !pop) begin
      fill_d = fill_q + 1'b1;
    end else if (!push && pop) begin
      fill_d = fill_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      rw_q        <= 1'b0;
      phy_q       <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      rw_q        <= rw_d;
      phy_q       <= phy_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      timeout_q   <= timeout_d;
      if (clr_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign smi_start_o    = (state_q == StIssue);
  assign smi_rw_o       = rw_q;
  assign smi_phy_addr_o = phy_q;
  assign smi_reg_addr_o = reg_q;
  assign smi_wr_data_o  = wdata_q;
  assign rsp_data_o     = rsp_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign busy_o         = (fill_q != '0) || (state_q != StIdle);
  assign timeout_o      = timeout_q;

endmodule
